// File: rtl/morse_pkg.sv
// Constants and state encoding shared by the Morse line driver, encoder, decoder and receiver.
package morse_pkg;
    localparam int W          = 24;
    localparam int LETTER_GAP = 3;
    localparam int WORD_GAP   = 7;
    localparam int DASH_LEN   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_SAMPLE
    } state_t;
endpackage

// File: rtl/morse_sync_edge.sv
// Two-flop synchronizer for the keyed line, plus rising-edge detect on the synchronized level.
module morse_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_s,
    output logic o_rise
);
    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_s    = r_s2;
    assign o_rise = r_s2 & ~r_prev;
endmodule

// File: rtl/morse_line_rx.sv
// Morse line receiver: samples the keyed line once per dot time, re-phases on each character's
// first mark, and hands left-aligned code words to the decoder through a valid/ready register.
//
//   state     | meaning
//   ST_IDLE   | line quiet, waiting for a mark to start
//   ST_ALIGN  | half-dot wait so the first sample lands mid-dot
//   ST_SAMPLE | one sample every K clocks, assembling the character
module morse_line_rx
    import morse_pkg::*;
#(
    parameter int K = 50
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_in,
    input  logic         i_ready,
    output logic [W-1:0] o_y,
    output logic [4:0]   o_len,
    output logic         o_err,
    output logic         o_valid,
    output logic         o_word,
    output logic         o_ovf
);
    localparam int CNT_W = $clog2(K);
    // The edge that loads the counter is itself one clock of the half-dot wait.
    localparam logic [CNT_W-1:0] P_HALF   = CNT_W'(K / 2 - 1);
    localparam logic [CNT_W-1:0] P_RELOAD = CNT_W'(K - 1);
    localparam logic [5:0]       P_W      = 6'(W);
    localparam logic [4:0]       P_LAST   = 5'(W - 1);
    localparam logic [2:0]       P_LG     = 3'(LETTER_GAP);
    localparam logic [2:0]       P_WG     = 3'(WORD_GAP);
    localparam logic [2:0]       P_DASH   = 3'(DASH_LEN);
    localparam logic [2:0]       P_MSAT   = 3'(DASH_LEN + 1);

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [W-1:0]     r_sr, w_sr_n;
    logic [4:0]       r_len, w_len_n;
    logic             r_cerr, w_cerr_n;
    logic [2:0]       r_mrun, w_mrun_n;
    logic [2:0]       r_zrun, w_zrun_n;
    logic             w_push, w_push_err, w_word_n, w_bad;
    logic [5:0]       w_pos;
    logic [4:0]       w_idx;
    logic             w_s, w_rise;
    logic [W-1:0]     r_y;
    logic [4:0]       r_olen;
    logic             r_oerr, r_valid, r_word, r_ovf;

    morse_sync_edge u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_in    (i_in),
        .o_s     (w_s),
        .o_rise  (w_rise)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_n;
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_sr_n     = r_sr;
        w_len_n    = r_len;
        w_cerr_n   = r_cerr;
        w_mrun_n   = r_mrun;
        w_zrun_n   = r_zrun;
        w_push     = 1'b0;
        w_push_err = 1'b0;
        w_word_n   = 1'b0;
        // Pending intra-character zeros are only meaningful once the character has a mark.
        w_pos      = (r_len == 5'd0) ? 6'd0 : ({1'b0, r_len} + {3'b000, r_zrun});
        w_idx      = P_LAST - w_pos[4:0];
        w_bad      = !((r_mrun == 3'd0) || (r_mrun == 3'd1) || (r_mrun == P_DASH));

        if (!i_en) begin
            w_state_n = ST_IDLE;
            w_cnt_n   = '0;
            w_sr_n    = '0;
            w_len_n   = 5'd0;
            w_cerr_n  = 1'b0;
            w_mrun_n  = 3'd0;
            w_zrun_n  = 3'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_rise) begin
                w_state_n = ST_ALIGN;
                w_cnt_n   = P_HALF;
                w_mrun_n  = 3'd0;
                w_zrun_n  = 3'd0;
            end
        end else if ((r_state == ST_SAMPLE) && w_rise && (r_zrun >= P_LG)) begin
            w_state_n = ST_ALIGN;
            w_cnt_n   = P_HALF;
        end else if (r_cnt != '0) begin
            w_cnt_n = r_cnt - CNT_W'(1);
        end else begin
            w_state_n = ST_SAMPLE;
            w_cnt_n   = P_RELOAD;
            if (w_s) begin
                if (w_pos < P_W) begin
                    w_sr_n[w_idx] = 1'b1;
                    w_len_n       = w_pos[4:0] + 5'd1;
                end else begin
                    w_len_n  = P_W[4:0];
                    w_cerr_n = 1'b1;
                end
                if (r_mrun < P_MSAT) w_mrun_n = r_mrun + 3'd1;
                if (r_mrun == P_DASH) w_cerr_n = 1'b1;
                w_zrun_n = 3'd0;
            end else begin
                w_mrun_n = 3'd0;
                w_zrun_n = r_zrun + 3'd1;
                if (w_bad) w_cerr_n = 1'b1;
                if (w_zrun_n == P_LG) begin
                    w_push     = (r_len != 5'd0);
                    w_push_err = r_cerr | w_bad;
                    w_sr_n     = '0;
                    w_len_n    = 5'd0;
                    w_cerr_n   = 1'b0;
                end
                if (w_zrun_n == P_WG) begin
                    w_word_n  = 1'b1;
                    w_state_n = ST_IDLE;
                    w_zrun_n  = 3'd0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_sr    <= '0;
            r_len   <= 5'd0;
            r_cerr  <= 1'b0;
            r_mrun  <= 3'd0;
            r_zrun  <= 3'd0;
            r_y     <= '0;
            r_olen  <= 5'd0;
            r_oerr  <= 1'b0;
            r_valid <= 1'b0;
            r_word  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_n;
            r_sr   <= w_sr_n;
            r_len  <= w_len_n;
            r_cerr <= w_cerr_n;
            r_mrun <= w_mrun_n;
            r_zrun <= w_zrun_n;
            r_word <= w_word_n;
            r_ovf  <= w_push && r_valid && !i_ready;
            if (w_push && (!r_valid || i_ready)) begin
                r_y     <= r_sr;
                r_olen  <= r_len;
                r_oerr  <= w_push_err;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_y     = r_y;
    assign o_len   = r_olen;
    assign o_err   = r_oerr;
    assign o_valid = r_valid;
    assign o_word  = r_word;
    assign o_ovf   = r_ovf;
endmodule
